// File: rtl/mpp_pkg.sv
// Shared types for the mpp_fifo read-side drain controller.
// PEEK_WIDTH lives here so every user is locked to the FIFO's peek width.
package mpp_pkg;

  localparam int unsigned PEEK_WIDTH = 4;
  localparam int unsigned LANE_W     = (PEEK_WIDTH > 1) ? $clog2(PEEK_WIDTH) : 1;

  // Bit i corresponds to peek lane i (lane 0 = FIFO head).
  typedef logic [0:PEEK_WIDTH-1] lane_mask_t;
  typedef logic [LANE_W-1:0]     lane_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PEEK,
    ST_WAIT,
    ST_SEND,
    ST_POP
  } state_t;

endpackage

// File: rtl/mpp_lane_sel.sv
// Finds the next valid lane in a peek mask, either from lane 0 or strictly above
// the current lane, and flags whether that lane is the highest valid one.
module mpp_lane_sel
  import mpp_pkg::*;
(
  input  lane_mask_t mask,
  input  lane_idx_t  lane,
  input  logic       from_start,
  output lane_idx_t  nxt_c,
  output logic       found_c,
  output logic       nxt_is_last_c
);

  always_comb begin
    nxt_c         = '0;
    found_c       = 1'b0;
    nxt_is_last_c = 1'b0;
    // Descending scan so the lowest qualifying lane is the one that sticks.
    for (int i = PEEK_WIDTH - 1; i >= 0; i--) begin
      if (mask[i] && (from_start || (lane_idx_t'(i) > lane))) begin
        nxt_c   = lane_idx_t'(i);
        found_c = 1'b1;
      end
    end
    if (found_c) begin
      nxt_is_last_c = 1'b1;
      for (int i = 0; i < PEEK_WIDTH; i++) begin
        if (mask[i] && (lane_idx_t'(i) > nxt_c)) begin
          nxt_is_last_c = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/mpp_fifo_drain.sv
// Read-side controller for mpp_fifo: peeks a batch, streams its valid lanes in
// order over valid/ready, then retires exactly the transferred lanes with one pop.
module mpp_fifo_drain
  import mpp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                                  i_clk,
  input  logic                                  i_nrst,
  input  logic                                  i_clear,
  input  logic                                  i_en,
  output logic                                  o_peek_en,
  input  logic [0:PEEK_WIDTH-1][DATA_WIDTH-1:0] i_peek_data,
  input  lane_mask_t                            i_valid_data,
  input  logic                                  i_peek_valid,
  input  logic                                  i_empty,
  output logic                                  o_pop_en,
  output lane_mask_t                            o_data_hit,
  output logic [DATA_WIDTH-1:0]                 o_data,
  output logic                                  o_valid,
  input  logic                                  i_ready,
  output logic                                  o_last,
  output logic                                  o_busy,
  output logic [CNT_WIDTH-1:0]                  o_drained
);

  typedef logic [0:PEEK_WIDTH-1][DATA_WIDTH-1:0] peek_data_t;

  state_t               state, state_nxt;
  lane_idx_t            lane, lane_nxt;
  lane_mask_t           capt_mask, mask_nxt;
  lane_mask_t           sent, sent_nxt;
  peek_data_t           capt_data, data_nxt;
  logic                 last_nxt;
  logic [CNT_WIDTH-1:0] cnt_nxt;

  logic                  valid_d, last_d, peek_d, pop_d, busy_d;
  logic [DATA_WIDTH-1:0] data_d;
  lane_mask_t            hit_d;

  lane_mask_t sel_mask;
  logic       sel_from_start;
  lane_idx_t  sel_nxt;
  logic       sel_found, sel_is_last;
  logic       xfer;

  // In WAIT the selector looks at the incoming peek mask to pick the first lane;
  // in SEND it walks the captured mask upward from the current lane.
  assign sel_from_start = (state == ST_WAIT);
  assign sel_mask       = sel_from_start ? i_valid_data : capt_mask;
  assign xfer           = o_valid && i_ready;

  mpp_lane_sel u_lane_sel (
    .mask          (sel_mask),
    .lane          (lane),
    .from_start    (sel_from_start),
    .nxt_c         (sel_nxt),
    .found_c       (sel_found),
    .nxt_is_last_c (sel_is_last)
  );

  // State and datapath registers; outputs are registered from the decoded next state.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state      <= ST_IDLE;
      lane       <= '0;
      capt_mask  <= '0;
      capt_data  <= '0;
      sent       <= '0;
      o_drained  <= '0;
      o_peek_en  <= 1'b0;
      o_pop_en   <= 1'b0;
      o_data_hit <= '0;
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_last     <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      state      <= state_nxt;
      lane       <= lane_nxt;
      capt_mask  <= mask_nxt;
      capt_data  <= data_nxt;
      sent       <= sent_nxt;
      o_drained  <= cnt_nxt;
      o_peek_en  <= peek_d;
      o_pop_en   <= pop_d;
      o_data_hit <= hit_d;
      o_data     <= data_d;
      o_valid    <= valid_d;
      o_last     <= last_d;
      o_busy     <= busy_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt = state;
    lane_nxt  = lane;
    mask_nxt  = capt_mask;
    data_nxt  = capt_data;
    sent_nxt  = sent;
    cnt_nxt   = o_drained;
    last_nxt  = o_last;

    case (state)
      ST_IDLE: begin
        if (i_en && !i_empty) begin
          state_nxt = ST_PEEK;
        end
      end
      ST_PEEK: begin
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_peek_valid) begin
          data_nxt = i_peek_data;
          mask_nxt = i_valid_data;
          sent_nxt = '0;
          if (!sel_found) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_SEND;
            lane_nxt  = sel_nxt;
            last_nxt  = sel_is_last;
          end
        end
      end
      ST_SEND: begin
        if (xfer) begin
          sent_nxt[lane] = 1'b1;
          cnt_nxt        = o_drained + CNT_WIDTH'(1);
          if (!sel_found) begin
            state_nxt = ST_POP;
            last_nxt  = 1'b0;
          end else begin
            lane_nxt = sel_nxt;
            last_nxt = sel_is_last;
          end
        end
      end
      ST_POP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // The FIFO is flushed by the same clear, so a partial batch is abandoned without a pop.
    if (i_clear) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      sent_nxt  = '0;
      last_nxt  = 1'b0;
    end
  end

  // Output decode from the next state.
  always_comb begin
    valid_d = (state_nxt == ST_SEND);
    data_d  = data_nxt[lane_nxt];
    last_d  = last_nxt && (state_nxt == ST_SEND);
    peek_d  = (state_nxt == ST_PEEK);
    pop_d   = (state_nxt == ST_POP);
    hit_d   = pop_d ? sent_nxt : '0;
    busy_d  = (state_nxt != ST_IDLE);
  end

endmodule

// File: tb/tb_mpp_fifo_drain.sv
// Directed bench for mpp_fifo_drain with a behavioural mpp_fifo model and
// scoreboards for streamed elements and pop hit masks.
module tb_mpp_fifo_drain;
  import mpp_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;
  localparam int unsigned PW = PEEK_WIDTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n;
  logic                  i_clear, i_en, i_peek_valid, i_empty, i_ready;
  logic [0:PW-1][DW-1:0] i_peek_data;
  lane_mask_t            i_valid_data;
  logic                  o_peek_en, o_pop_en, o_valid, o_last, o_busy;
  lane_mask_t            o_data_hit;
  logic [DW-1:0]         o_data;
  logic [CW-1:0]         o_drained;

  mpp_fifo_drain #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .i_clk        (clk),
    .i_nrst       (rst_n),
    .i_clear      (i_clear),
    .i_en         (i_en),
    .o_peek_en    (o_peek_en),
    .i_peek_data  (i_peek_data),
    .i_valid_data (i_valid_data),
    .i_peek_valid (i_peek_valid),
    .i_empty      (i_empty),
    .o_pop_en     (o_pop_en),
    .o_data_hit   (o_data_hit),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_last       (o_last),
    .o_busy       (o_busy),
    .o_drained    (o_drained)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t          exp_q[$];
  lane_mask_t    hit_q[$];
  logic [DW-1:0] fifo_q[$];

  int            checks = 0;
  int            errors = 0;
  int            peek_cnt = 0;
  logic          ovr_en = 1'b0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] stall_data = '0;
  logic          stall_last = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_elem(input logic [DW-1:0] d, input logic expect_it, input logic last);
    fifo_q.push_back(d);
    i_empty = 1'b0;
    if (expect_it) exp_q.push_back('{data: d, last: last});
  endtask

  // Stream and pop checks, sampled mid-cycle.
  task automatic monitor();
    exp_t e;
    if (!rst_n) return;
    if (o_valid) begin
      if (stall_prev) begin
        chk("stall_data", 32'(o_data), 32'(stall_data));
        chk("stall_last", 32'(o_last), 32'(stall_last));
      end
      if (i_ready) begin
        chk("xfer_expected", 32'(exp_q.size() > 0), 32'(1));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("stream_data", 32'(o_data), 32'(e.data));
          chk("stream_last", 32'(o_last), 32'(e.last));
        end
      end
    end
    stall_prev = o_valid && !i_ready;
    stall_data = o_data;
    stall_last = o_last;
    if (o_pop_en) begin
      chk("pop_expected", 32'(hit_q.size() > 0), 32'(1));
      if (hit_q.size() > 0) chk("data_hit", 32'(o_data_hit), 32'(hit_q.pop_front()));
    end else begin
      chk("hit_zero_no_pop", 32'(o_data_hit), 32'(0));
    end
  endtask

  // One clock: check at negedge, then the FIFO model reacts just after posedge.
  task automatic tick();
    logic       pk, pp;
    lane_mask_t ph;
    @(negedge clk);
    monitor();
    pk = o_peek_en;
    pp = o_pop_en;
    ph = o_data_hit;
    @(posedge clk);
    #1;
    i_peek_valid = 1'b0;
    i_valid_data = '0;
    if (pp && rst_n) begin
      for (int i = 0; i < PW; i++) if (ph[i] && fifo_q.size() > 0) void'(fifo_q.pop_front());
    end
    if (pk && rst_n) begin
      peek_cnt++;
      for (int i = 0; i < PW; i++) begin
        if (i < fifo_q.size() && !ovr_en) begin
          i_peek_data[i]  = fifo_q[i];
          i_valid_data[i] = 1'b1;
        end else begin
          i_peek_data[i]  = '0;
        end
      end
      i_peek_valid = 1'b1;
    end
    i_empty = (fifo_q.size() == 0);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!(exp_q.size() == 0 && hit_q.size() == 0 && !o_busy) && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 32'(exp_q.size() + hit_q.size()), 32'(0));
  endtask

  initial begin
    int n;
    rst_n = 1'b0; i_clear = 1'b0; i_en = 1'b0; i_peek_data = '0; i_valid_data = '0;
    i_peek_valid = 1'b0; i_empty = 1'b1; i_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(o_valid), 32'(0));
    chk("rst_busy", 32'(o_busy), 32'(0));
    chk("rst_drained", 32'(o_drained), 32'(0));
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", 32'(o_busy), 32'(0));

    // Nine elements in three batches: 4, 4, 1.
    for (int k = 1; k <= 9; k++) push_elem(DW'(k), 1'b1, (k == 4 || k == 8 || k == 9));
    hit_q.push_back(4'b1111); hit_q.push_back(4'b1111); hit_q.push_back(4'b1000);
    i_en = 1'b1; i_ready = 1'b1;
    wait_idle("t2_done");
    chk("t2_drained", 32'(o_drained), 32'(9));
    chk("t2_busy_low", 32'(o_busy), 32'(0));
    chk("t2_fifo_empty", 32'(fifo_q.size()), 32'(0));

    // Two-lane batch with backpressure on both elements.
    i_ready = 1'b0;
    push_elem(8'hA1, 1'b1, 1'b0);
    push_elem(8'hB2, 1'b1, 1'b1);
    hit_q.push_back(4'b1100);
    n = 0;
    while (!o_valid && n < 20) begin tick(); n++; end
    chk("t3_valid_seen", 32'(o_valid), 32'(1));
    chk("t3_first_data", 32'(o_data), 32'(8'hA1));
    chk("t3_first_last", 32'(o_last), 32'(0));
    for (int k = 0; k < 5; k++) begin
      i_ready = (k == 1 || k == 4);
      tick();
      if (k == 1) begin
        chk("t3_second_data", 32'(o_data), 32'(8'hB2));
        chk("t3_second_last", 32'(o_last), 32'(1));
      end
    end
    i_ready = 1'b1;
    wait_idle("t3_done");
    chk("t3_drained", 32'(o_drained), 32'(11));

    // Peek returns an all-invalid mask: back to IDLE without a pop.
    ovr_en = 1'b1;
    push_elem(8'h55, 1'b0, 1'b0);
    n = 0;
    while (peek_cnt == 0 || n < 2) begin
      tick(); n++;
      if (n > 30) break;
    end
    i_en = 1'b0;
    repeat (6) tick();
    chk("t4_busy_low", 32'(o_busy), 32'(0));
    chk("t4_not_popped", 32'(fifo_q.size()), 32'(1));
    chk("t4_drained", 32'(o_drained), 32'(11));
    fifo_q.delete(); i_empty = 1'b1; ovr_en = 1'b0;

    // Clear after two transfers, coinciding with the third transfer.
    for (int k = 0; k < 4; k++) push_elem(8'hC0 + DW'(k), (k < 3), 1'b0);
    i_en = 1'b1; i_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 1 && n < 30) begin tick(); n++; end
    chk("t5_two_sent", 32'(exp_q.size()), 32'(1));
    i_clear = 1'b1; fifo_q.delete(); i_empty = 1'b1;
    tick();
    i_clear = 1'b0;
    chk("t5_valid_low", 32'(o_valid), 32'(0));
    chk("t5_drained_zero", 32'(o_drained), 32'(0));
    chk("t5_busy_low", 32'(o_busy), 32'(0));
    chk("t5_pop_low", 32'(o_pop_en), 32'(0));
    repeat (5) tick();
    chk("t5_still_zero", 32'(o_drained), 32'(0));

    // i_en dropped after the first transfer: batch completes, no new peek.
    for (int k = 0; k < 4; k++) push_elem(8'hD0 + DW'(k), 1'b1, (k == 3));
    for (int k = 0; k < 4; k++) push_elem(8'hE0 + DW'(k), 1'b0, 1'b0);
    hit_q.push_back(4'b1111);
    n = 0;
    while (exp_q.size() != 3 && n < 30) begin tick(); n++; end
    chk("t6_first_xfer", 32'(exp_q.size()), 32'(3));
    i_en = 1'b0;
    peek_cnt = 0;
    repeat (12) tick();
    chk("t6_no_peek", 32'(peek_cnt), 32'(0));
    chk("t6_batch_done", 32'(exp_q.size() + hit_q.size()), 32'(0));
    chk("t6_fifo_left", 32'(fifo_q.size()), 32'(4));
    chk("t6_drained", 32'(o_drained), 32'(4));
    chk("t6_busy_low", 32'(o_busy), 32'(0));
    fifo_q.delete(); i_empty = 1'b1;

    // Asynchronous reset while stalled in SEND.
    i_en = 1'b1; i_ready = 1'b0;
    for (int k = 0; k < 4; k++) push_elem(8'hF0 + DW'(k), 1'b0, 1'b0);
    n = 0;
    while (!o_valid && n < 20) begin tick(); n++; end
    chk("t1_in_send", 32'(o_valid), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_valid", 32'(o_valid), 32'(0));
    chk("t1_data", 32'(o_data), 32'(0));
    chk("t1_last", 32'(o_last), 32'(0));
    chk("t1_busy", 32'(o_busy), 32'(0));
    chk("t1_peek", 32'(o_peek_en), 32'(0));
    chk("t1_pop", 32'(o_pop_en), 32'(0));
    chk("t1_hit", 32'(o_data_hit), 32'(0));
    chk("t1_drained", 32'(o_drained), 32'(0));
    fifo_q.delete(); exp_q.delete(); hit_q.delete();
    i_empty = 1'b1; i_en = 1'b0; stall_prev = 1'b0;
    rst_n = 1'b1;
    repeat (3) tick();
    chk("t1_idle_busy", 32'(o_busy), 32'(0));
    chk("t1_idle_valid", 32'(o_valid), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
